prog_divide_n: RTL and testbench

//  Runtime-programmable divide-by-N counter. Supersedes the fixed divide-by-N block.

---
 rtl/prog_divide_n.sv | 105 ++++++++++
 tb/tb_prog_divide_n.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/prog_divide_n.sv
// Runtime-programmable divide-by-N counter with pulse/square/toggle outputs.
// Divisor and mode changes are staged and applied only at the wrap edge (falling edge of CLK).
module prog_divide_n #(
    parameter int M         = 4,
    parameter int N_DEFAULT = 10
) (
    input  logic         CLK,
    input  logic         CLEAR,
    input  logic         EN,
    input  logic         LOAD,
    input  logic [M-1:0] DIV,
    input  logic [1:0]   MODE,
    output logic [M-1:0] COUNT,
    output logic         OUT,
    output logic         TC,
    output logic         ERR
);

    typedef enum logic [1:0] {
        MODE_PULSE  = 2'b00,
        MODE_SQUARE = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    localparam logic [M-1:0] D_RESET = M'(N_DEFAULT);
    localparam logic [M-1:0] ONE     = M'(1);
    localparam logic [M-1:0] TWO     = M'(2);

    logic [M-1:0] count_reg, count_next;
    logic [M-1:0] d_reg, d_next;
    mode_t        mode_reg, mode_next;
    logic [M-1:0] pend_d_reg, pend_d_next;
    mode_t        pend_mode_reg, pend_mode_next;
    logic         pend_valid_reg, pend_valid_next;
    logic         out_reg, out_next;
    logic         err_reg, err_next;

    logic load_ok;
    logic wrap;

    assign load_ok = LOAD && (DIV >= TWO);
    assign wrap    = EN && (count_reg == d_reg - ONE);

    always_comb begin
        count_next      = count_reg;
        d_next          = d_reg;
        mode_next       = mode_reg;
        pend_d_next     = pend_d_reg;
        pend_mode_next  = pend_mode_reg;
        pend_valid_next = pend_valid_reg;
        out_next        = out_reg;
        err_next        = LOAD && (DIV < TWO);

        if (load_ok) begin
            pend_d_next     = DIV;
            pend_mode_next  = mode_t'(MODE);
            pend_valid_next = 1'b1;
        end

        // A LOAD on the wrap edge itself is folded in through the *_next pending values.
        if (wrap && pend_valid_next) begin
            d_next          = pend_d_next;
            mode_next       = pend_mode_next;
            pend_valid_next = 1'b0;
        end

        if (EN) begin
            count_next = wrap ? '0 : count_reg + ONE;
            case (mode_next)
                MODE_SQUARE: out_next = (count_next < (d_next >> 1));
                MODE_TOGGLE: out_next = wrap ? ~out_reg : out_reg;
                default:     out_next = (count_next == d_next - ONE);
            endcase
        end
    end

    always_ff @(negedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            count_reg      <= '0;
            d_reg          <= D_RESET;
            mode_reg       <= MODE_PULSE;
            pend_d_reg     <= '0;
            pend_mode_reg  <= MODE_PULSE;
            pend_valid_reg <= 1'b0;
            out_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            count_reg      <= count_next;
            d_reg          <= d_next;
            mode_reg       <= mode_next;
            pend_d_reg     <= pend_d_next;
            pend_mode_reg  <= pend_mode_next;
            pend_valid_reg <= pend_valid_next;
            out_reg        <= out_next;
            err_reg        <= err_next;
        end
    end

    assign COUNT = count_reg;
    assign OUT   = out_reg;
    assign TC    = (count_reg == d_reg - ONE);
    assign ERR   = err_reg;

endmodule

// File: tb/tb_prog_divide_n.sv
// Directed bench for prog_divide_n: defaults, async clear, square/toggle modes,
// illegal divisor, enable hold and load on the wrap edge.
module tb_prog_divide_n;

    logic       clk = 1'b1;
    logic       clear;
    logic       en;
    logic       load;
    logic [3:0] div;
    logic [1:0] mode;
    logic [3:0] count;
    logic       out;
    logic       tc;
    logic       err;

    int tests = 0;
    int fails = 0;

    prog_divide_n #(.M(4), .N_DEFAULT(10)) dut (
        .CLK   (clk),
        .CLEAR (clear),
        .EN    (en),
        .LOAD  (load),
        .DIV   (div),
        .MODE  (mode),
        .COUNT (count),
        .OUT   (out),
        .TC    (tc),
        .ERR   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int c, input int o, input int t, input int e);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".out"},   32'(out),   32'(o));
        chk({tag, ".tc"},    32'(tc),    32'(t));
        chk({tag, ".err"},   32'(err),   32'(e));
        $display("[TB] %s count=%0d out=%0d tc=%0d err=%0d", tag, count, out, tc, err);
    endtask

    // one active (falling) edge, then sample 1 time unit later
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_load(input logic l, input logic [3:0] d, input logic [1:0] m);
        load = l;
        div  = d;
        mode = m;
    endtask

    initial begin
        clear = 1'b1;
        en    = 1'b0;
        set_load(1'b0, 4'd0, 2'b00);
        #12;
        chk_state("reset", 0, 0, 0, 0);
        clear = 1'b0;

        // Defaults: divide by 10, pulse mode
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            chk_state($sformatf("dflt%0d", i), (i + 1) % 10,
                      ((i + 1) % 10 == 9) ? 1 : 0, ((i + 1) % 10 == 9) ? 1 : 0, 0);
        end

        // Asynchronous clear at COUNT=6, no clock edge involved
        for (int i = 0; i < 6; i++) step();
        chk_state("pre_clear", 6, 0, 0, 0);
        #2 clear = 1'b1;
        #1;
        chk_state("async_clear", 0, 0, 0, 0);
        #1 clear = 1'b0;

        // Load 5/square mid-period at COUNT=3: current period of 10 finishes first
        for (int i = 0; i < 3; i++) step();
        set_load(1'b1, 4'd5, 2'b01);
        step();
        set_load(1'b0, 4'd0, 2'b00);
        chk_state("ld5_cnt4", 4, 0, 0, 0);
        for (int i = 5; i <= 9; i++) begin
            step();
            chk_state($sformatf("old%0d", i), i, (i == 9) ? 1 : 0, (i == 9) ? 1 : 0, 0);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            chk_state($sformatf("sq%0d", k), k % 5, (k % 5 < 2) ? 1 : 0, (k % 5 == 4) ? 1 : 0, 0);
        end

        // Load 3/toggle at COUNT=0; takes effect at the following wrap
        step();
        chk_state("sq_wrap", 0, 1, 0, 0);
        set_load(1'b1, 4'd3, 2'b10);
        step();
        set_load(1'b0, 4'd0, 2'b00);
        chk_state("ld3_cnt1", 1, 1, 0, 0);
        step(); chk_state("sq_c2", 2, 0, 0, 0);
        step(); chk_state("sq_c3", 3, 0, 0, 0);
        step(); chk_state("sq_c4", 4, 0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            step();
            chk_state($sformatf("tg%0d", k), k % 3, ((k / 3) % 2 == 0) ? 1 : 0, (k % 3 == 2) ? 1 : 0, 0);
        end

        // Illegal divisor: ERR pulses one cycle, active divisor stays 3
        step();
        chk_state("tg_wrap", 0, 1, 0, 0);
        set_load(1'b1, 4'd1, 2'b00);
        step();
        set_load(1'b0, 4'd0, 2'b00);
        chk_state("div1_err", 1, 1, 0, 1);
        step(); chk_state("div1_err_clr", 2, 1, 1, 0);
        step(); chk_state("div1_wrap", 0, 0, 0, 0);
        step(); chk_state("div1_c1", 1, 0, 0, 0);
        step(); chk_state("div1_c2", 2, 0, 1, 0);

        // Legal load then illegal load: pending legal value survives
        step(); chk_state("pv_c0", 0, 1, 0, 0);
        set_load(1'b1, 4'd10, 2'b00);
        step(); chk_state("pv_ld10", 1, 1, 0, 0);
        set_load(1'b1, 4'd0, 2'b00);
        step(); chk_state("pv_ld0", 2, 1, 1, 1);
        set_load(1'b0, 4'd0, 2'b00);
        step(); chk_state("pv_wrap", 0, 0, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk_state($sformatf("d10_%0d", i), i, 0, 0, 0);
        end

        // EN=0 for 4 edges at COUNT=7, then resume and load DIV=4 on the wrap edge
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_state($sformatf("hold%0d", i), 7, 0, 0, 0);
        end
        en = 1'b1;
        step(); chk_state("resume8", 8, 0, 0, 0);
        step(); chk_state("resume9", 9, 1, 1, 0);
        set_load(1'b1, 4'd4, 2'b00);
        step();
        set_load(1'b0, 4'd0, 2'b00);
        chk_state("wrapld_c0", 0, 0, 0, 0);
        step(); chk_state("d4_c1", 1, 0, 0, 0);
        step(); chk_state("d4_c2", 2, 0, 0, 0);
        step(); chk_state("d4_c3", 3, 1, 1, 0);
        step(); chk_state("d4_wrap", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
